// File: rtl/glb_banked_dpram_if.sv
// Request/grant and read-return signals for both ports of the banked
// global-buffer RAM. The requester drives the master side; the RAM uses
// the slave side.
interface glb_banked_dpram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR       = 10
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR-1:0]       a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR-1:0]       b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/glb_banked_dpram.sv
// Multi-bank dual-port global-buffer SRAM. Words are interleaved across
// NUM_BANKS single-access banks on the low address bits. Ports A and B each
// issue one read or write per cycle; same-bank conflicts are resolved by a
// round-robin priority that hands the next conflict to the previous loser.
// Two reads of the identical address share one bank access and are both
// granted. Read data returns RD_LAT cycles (1 or 2) after the grant edge.
// Internally port A is index 0 and port B is index 1.
module glb_banked_dpram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LAT     = 1,
    localparam int ADDR      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    glb_banked_dpram_if.slave   bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR - BANK_W;
    localparam int ROWS   = DEPTH / NUM_BANKS;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            gnt;
    logic [ADDR-1:0]       addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [BANK_W-1:0]     bank  [2];
    logic [ROW_W-1:0]      row   [2];

    logic  same_bank;
    logic  broadcast;
    logic  conflict;
    prio_e prio_q;
    prio_e prio_d;

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

    logic [1:0]            vld_p1_d;
    logic [1:0]            vld_p1_q;
    logic [DATA_WIDTH-1:0] data_p1_d [2];
    logic [DATA_WIDTH-1:0] data_p1_q [2];

    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata [2];

    assign req      = {bus.b_req, bus.a_req};
    assign we       = {bus.b_we,  bus.a_we};
    assign addr[0]  = bus.a_addr;
    assign addr[1]  = bus.b_addr;
    assign wdata[0] = bus.a_wdata;
    assign wdata[1] = bus.b_wdata;

    assign bus.a_gnt    = gnt[0];
    assign bus.b_gnt    = gnt[1];
    assign bus.a_rvalid = rvalid[0];
    assign bus.b_rvalid = rvalid[1];
    assign bus.a_rdata  = rdata[0];
    assign bus.b_rdata  = rdata[1];

    // Split each address into bank select (low bits) and row within the bank.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bank[p] = addr[p][BANK_W-1:0];
            row[p]  = addr[p][ADDR-1:BANK_W];
        end
    end

    // Grant arbitration and next round-robin priority.
    always_comb begin
        same_bank = (bank[0] == bank[1]);
        // Identical-address reads need only one bank access, so both may go.
        broadcast = (addr[0] == addr[1]) && !we[0] && !we[1];
        conflict  = req[0] && req[1] && same_bank && !broadcast;
        gnt[0]    = req[0] && (!conflict || (prio_q == PRIO_A));
        gnt[1]    = req[1] && (!conflict || (prio_q == PRIO_B));
        prio_d    = prio_q;
        if (conflict) begin
            // The loser of this conflict wins the next one.
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
        end
    end

    // Priority register; A is favoured out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Bank writes. Two granted writes always target different banks.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (gnt[p] && we[p]) begin
                mem[bank[p]][row[p]] <= wdata[p];
            end
        end
    end

    // Stage 1 read capture: contents as of the grant edge; data holds when idle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            vld_p1_d[p]  = gnt[p] && !we[p];
            data_p1_d[p] = vld_p1_d[p] ? mem[bank[p]][row[p]] : data_p1_q[p];
        end
    end

    // Stage 1 read register; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= '0;
            for (int p = 0; p < 2; p++) begin
                data_p1_q[p] <= '0;
            end
        end else begin
            vld_p1_q <= vld_p1_d;
            for (int p = 0; p < 2; p++) begin
                data_p1_q[p] <= data_p1_d[p];
            end
        end
    end

    // RD_LAT of 2 adds an output register; any other value behaves as 1.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [1:0]            vld_p2_d;
            logic [1:0]            vld_p2_q;
            logic [DATA_WIDTH-1:0] data_p2_d [2];
            logic [DATA_WIDTH-1:0] data_p2_q [2];

            // Stage 2 advances only when stage 1 holds a returned read.
            always_comb begin
                vld_p2_d = vld_p1_q;
                for (int p = 0; p < 2; p++) begin
                    data_p2_d[p] = vld_p1_q[p] ? data_p1_q[p] : data_p2_q[p];
                end
            end

            // Stage 2 output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p2_q <= '0;
                    for (int p = 0; p < 2; p++) begin
                        data_p2_q[p] <= '0;
                    end
                end else begin
                    vld_p2_q <= vld_p2_d;
                    for (int p = 0; p < 2; p++) begin
                        data_p2_q[p] <= data_p2_d[p];
                    end
                end
            end

            assign rvalid   = vld_p2_q;
            assign rdata[0] = data_p2_q[0];
            assign rdata[1] = data_p2_q[1];
        end else begin : g_lat1
            assign rvalid   = vld_p1_q;
            assign rdata[0] = data_p1_q[0];
            assign rdata[1] = data_p1_q[1];
        end
    endgenerate
endmodule

// File: tb/tb_glb_banked_dpram.sv
// Scoreboard bench for glb_banked_dpram: one RD_LAT=1 and one RD_LAT=2
// instance see identical directed stimulus. Grants are compared before each
// rising edge; expected read returns are queued at grant time and popped by
// a monitor that also checks the return cycle against the latency.
module tb_glb_banked_dpram;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    glb_banked_dpram_if #(.DATA_WIDTH(DW), .ADDR(AW)) if1 ();
    glb_banked_dpram_if #(.DATA_WIDTH(DW), .ADDR(AW)) if2 ();

    assign if1.a_req = a_req;  assign if1.a_we = a_we;
    assign if1.a_addr = a_addr; assign if1.a_wdata = a_wdata;
    assign if1.b_req = b_req;  assign if1.b_we = b_we;
    assign if1.b_addr = b_addr; assign if1.b_wdata = b_wdata;
    assign if2.a_req = a_req;  assign if2.a_we = a_we;
    assign if2.a_addr = a_addr; assign if2.a_wdata = a_wdata;
    assign if2.b_req = b_req;  assign if2.b_we = b_we;
    assign if2.b_addr = b_addr; assign if2.b_wdata = b_wdata;

    glb_banked_dpram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(4), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    glb_banked_dpram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(4), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    // Queue index: 0 = lat1 port A, 1 = lat1 port B, 2 = lat2 port A, 3 = lat2 port B.
    exp_t          q [4][$];
    logic          rv [4];
    logic [DW-1:0] rd [4];
    int            lat [4] = '{1, 1, 2, 2};
    int            cnt = 0;
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] mdl [16];
    exp_t          mon_e;

    assign rv[0] = if1.a_rvalid; assign rd[0] = if1.a_rdata;
    assign rv[1] = if1.b_rvalid; assign rd[1] = if1.b_rdata;
    assign rv[2] = if2.a_rvalid; assign rd[2] = if2.a_rdata;
    assign rv[3] = if2.b_rvalid; assign rd[3] = if2.b_rdata;

    always @(posedge clk) cnt <= cnt + 1;

    // Monitor: every rvalid must match the oldest expectation, in data and cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rv[k] !== 1'b0) begin
                vectors++;
                if (q[k].size() == 0) begin
                    miscompares++;
                    $display("FAIL rvalid_unexpected[%0d]: got rvalid=%b data=%h at cycle %0d, required no return",
                             k, rv[k], rd[k], cnt);
                end else begin
                    mon_e = q[k].pop_front();
                    if (rd[k] !== mon_e.d || cnt != mon_e.c + lat[k]) begin
                        miscompares++;
                        $display("FAIL rdata[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                                 k, rd[k], cnt, mon_e.d, mon_e.c + lat[k]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic set_a(input bit r, input bit w, input int ad, input int d);
        a_req = r; a_we = w; a_addr = AW'(ad); a_wdata = DW'(d);
    endtask

    task automatic set_b(input bit r, input bit w, input int ad, input int d);
        b_req = r; b_we = w; b_addr = AW'(ad); b_wdata = DW'(d);
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step(input string nm, input bit ea, input bit eb);
        exp_t e;
        #4;
        chk({nm, "/a_gnt_lat1"}, {31'd0, if1.a_gnt}, {31'd0, ea});
        chk({nm, "/b_gnt_lat1"}, {31'd0, if1.b_gnt}, {31'd0, eb});
        chk({nm, "/a_gnt_lat2"}, {31'd0, if2.a_gnt}, {31'd0, ea});
        chk({nm, "/b_gnt_lat2"}, {31'd0, if2.b_gnt}, {31'd0, eb});
        if (ea && a_req && !a_we) begin
            e.d = mdl[a_addr[3:0]]; e.c = cnt;
            q[0].push_back(e); q[2].push_back(e);
        end
        if (eb && b_req && !b_we) begin
            e.d = mdl[b_addr[3:0]]; e.c = cnt;
            q[1].push_back(e); q[3].push_back(e);
        end
        @(posedge clk);
        #1;
        if (ea && a_req && a_we) mdl[a_addr[3:0]] = a_wdata;
        if (eb && b_req && b_we) mdl[b_addr[3:0]] = b_wdata;
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string nm);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s/rvalid[%0d]", nm, k), {31'd0, rv[k]}, 32'd0);
            chk($sformatf("%s/rdata[%0d]", nm, k), {16'd0, rd[k]}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        // Conflicting writes held through reset; A is favoured so @0 is written.
        rst_n = 1'b0;
        set_a(1, 1, 0, 'h1111);
        set_b(1, 1, 4, 'h4444);
        mdl[0] = 16'h1111;
        repeat (3) @(negedge clk);
        #2;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First conflict after reset goes to A, then B after one cycle.
        step("rst_conflict", 1, 0);
        set_a(0, 0, 0, 0);
        step("b_after_wait", 0, 1);

        // Preload different-bank pairs; both ports granted each cycle.
        set_a(1, 1, 1, 'h0101); set_b(1, 1, 2, 'h0202); step("pre12", 1, 1);
        set_a(1, 1, 5, 'h1234); set_b(1, 1, 3, 'h0303); step("wr5", 1, 1);
        // Write in one cycle is visible to a read in the next.
        set_a(1, 0, 5, 0);      set_b(1, 1, 6, 'h0606); step("rd5", 1, 1);
        set_a(1, 1, 7, 'h0707); set_b(1, 1, 8, 'h0808); step("pre78", 1, 1);

        // Same-bank reads with priority at B: B first, A one cycle later.
        set_a(1, 0, 4, 0); set_b(1, 0, 8, 0); step("rdconf_b", 0, 1);
        set_b(0, 0, 0, 0);                    step("rdconf_a", 1, 0);

        // Same-address write/write with priority at A: A then B; B's data sticks.
        set_a(1, 1, 8, 'hAAAA); set_b(1, 1, 8, 'hBBBB); step("ww_a", 1, 0);
        set_a(0, 0, 0, 0);                              step("ww_b", 0, 1);
        set_a(1, 0, 8, 0); set_b(0, 0, 0, 0);           step("rd8", 1, 0);

        // Broadcast read leaves priority at B.
        set_a(1, 0, 3, 0); set_b(1, 0, 3, 0); step("bcast", 1, 1);
        set_a(1, 0, 0, 0); set_b(1, 0, 4, 0); step("prio_kept", 0, 1);
        set_b(0, 0, 0, 0);                    step("prio_kept_a", 1, 0);

        // Same-address write/read: the write blocks the read for a cycle.
        set_a(1, 1, 1, 'h5555); set_b(1, 0, 1, 0); step("wr_blocks_rd", 1, 0);
        set_a(0, 0, 0, 0);                         step("rd_after_wr", 0, 1);

        // Streams on always-different banks: both granted every cycle.
        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, i, 0); set_b(1, 0, i + 1, 0);
            step($sformatf("stream%0d", i), 1, 1);
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("drain[%0d]", k), q[k].size(), 32'd0);

        // Stream again and reset mid-flight: pending reads must never return.
        for (int i = 0; i < 4; i++) begin
            set_a(1, 0, i, 0); set_b(1, 0, i + 1, 0);
            step($sformatf("stream2_%0d", i), 1, 1);
        end
        #1;
        rst_n = 1'b0;
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) q[k].delete();
        #1;
        chk_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Priority back to A after reset; memory contents survive reset.
        set_a(1, 0, 0, 0); set_b(1, 0, 4, 0); step("post_rst_a", 1, 0);
        set_a(0, 0, 0, 0);                    step("post_rst_b", 0, 1);
        set_b(0, 0, 0, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("final_drain[%0d]", k), q[k].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
